// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake game: the direction encoding, its 2-bit
// type and a helper that returns the opposite direction. The game top level,
// the snake engine and dir_input_ctrl all import this package.
// -----------------------------------------------------------------------------
package snake_pkg;

    typedef logic [1:0] dir_t;

    // Opposite pairs differ only in bit 0 (LEFT/RIGHT, UP/DOWN).
    localparam dir_t DIR_LEFT  = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_UP    = 2'd2;
    localparam dir_t DIR_DOWN  = 2'd3;

    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: 2-flop synchroniser, debounce counter that
// accepts a level change only after DEBOUNCE_CYCLES consecutive differing
// samples, and a one-clock pulse on each 0->1 change of the debounced level.
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-high
//   btn_i    raw asynchronous button level
//   press_o  one-clock pulse on a debounced rising edge
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synced level disagrees with the stable
    // level; any agreement (a bounce back) restarts the count from zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    // High for exactly the one cycle after the stable level rises.
    assign press_o = stable_q & ~prev_q;

endmodule

// File: rtl/dir_input_ctrl.sv
// -----------------------------------------------------------------------------
// dir_input_ctrl
// Producer side of the player-direction interface. Four debounced buttons
// generate candidate turns; legal turns (not a repeat, not a reversal of the
// most recent direction) are buffered in a small FIFO that the game engine
// drains one entry per game step.
//
// Strobe semantics: tick_i, restart_i, any_press_o and overflow_o are all
// single-cycle pulses with no backpressure. tick_i pops one turn when the
// queue is non-empty and is otherwise ignored; restart_i wins over every
// other same-cycle event.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   btn_u/l/d/r     raw asynchronous buttons
//   tick_i          pop one queued turn into dir_o
//   restart_i       empty the queue and return to RIGHT
//   dir_o           current direction (0=LEFT 1=RIGHT 2=UP 3=DOWN)
//   q_count_o       number of queued turns
//   any_press_o     pulse on any debounced press, accepted or not
//   overflow_o      pulse when a legal press is dropped on a full queue
// -----------------------------------------------------------------------------
module dir_input_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           btn_u,
    input  logic                           btn_l,
    input  logic                           btn_d,
    input  logic                           btn_r,
    input  logic                           tick_i,
    input  logic                           restart_i,
    output logic [1:0]                     dir_o,
    output logic [$clog2(QUEUE_DEPTH):0]   q_count_o,
    output logic                           any_press_o,
    output logic                           overflow_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CW    = PTR_W + 1;

    // press[0]=U, [1]=L, [2]=D, [3]=R; index order is also priority order.
    logic [3:0] press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_u (
        .clk(clk), .rst(rst), .btn_i(btn_u), .press_o(press[0]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_l (
        .clk(clk), .rst(rst), .btn_i(btn_l), .press_o(press[1]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_d (
        .clk(clk), .rst(rst), .btn_i(btn_d), .press_o(press[2]));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_r (
        .clk(clk), .rst(rst), .btn_i(btn_r), .press_o(press[3]));

    dir_t             fifo_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    dir_t             dir_q,    dir_d;
    logic             any_press_q, any_press_d;
    logic             overflow_q,  overflow_d;

    dir_t             cand;
    dir_t             last;
    logic             press_valid;
    logic             legal;
    logic             full;
    logic             pop;
    logic             push;

    // Fixed-priority pick of a single candidate; losers are dropped.
    always_comb begin
        press_valid = |press;
        cand        = DIR_RIGHT;
        if (press[0])      cand = DIR_UP;
        else if (press[1]) cand = DIR_LEFT;
        else if (press[2]) cand = DIR_DOWN;
        else if (press[3]) cand = DIR_RIGHT;
    end

    // The reference is the most recently queued turn (tail), not the head:
    // a new press must be legal relative to where the snake will be heading
    // after everything already queued. Taken before any same-cycle pop.
    always_comb begin
        full  = (count_q == CW'(QUEUE_DEPTH));
        last  = (count_q != '0) ? fifo_q[wr_ptr_q - PTR_W'(1)] : dir_q;
        legal = press_valid && (cand != last) && (cand != opposite(last));
        pop   = tick_i && (count_q != '0);
        // A full queue still takes the press when a pop frees a slot.
        push  = legal && (!full || pop);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dir_d       = dir_q;
        any_press_d = press_valid;
        overflow_d  = 1'b0;
        if (restart_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dir_d    = DIR_RIGHT;
        end else begin
            overflow_d = legal && full && !pop;
            if (pop) begin
                dir_d    = fifo_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_q[i] <= DIR_LEFT;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dir_q       <= DIR_RIGHT;
            any_press_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push && !restart_i) begin
                fifo_q[wr_ptr_q] <= cand;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            any_press_q <= any_press_d;
            overflow_q  <= overflow_d;
        end
    end

    assign dir_o       = dir_q;
    assign q_count_o   = count_q;
    assign any_press_o = any_press_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_dir_input_ctrl.sv
module tb_dir_input_ctrl;

  localparam int D     = 4;
  localparam int CNT_W = 3;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;      // [0]=U [1]=L [2]=D [3]=R
  logic       tick;
  logic       restart;
  logic [1:0] dir_o;
  logic [2:0] q_count_o;
  logic       any_press_o;
  logic       overflow_o;

  always #5 clk = ~clk;

  dir_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .btn_u(raw[0]), .btn_l(raw[1]), .btn_d(raw[2]), .btn_r(raw[3]),
    .tick_i(tick), .restart_i(restart),
    .dir_o(dir_o), .q_count_o(q_count_o),
    .any_press_o(any_press_o), .overflow_o(overflow_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]   exp_q[$];     // queued turns, head first
  logic [1:0]   m_dir;
  logic         m_any;
  logic         m_ovf;
  logic [1:0]   pipe  [4];    // raw samples still in flight through the synchroniser
  logic [D-1:0] hist  [4];    // last D synced samples, newest in bit 0
  int           hist_n[4];
  logic         stable[4];
  logic         rise1 [4];    // debounced level rose at the previous edge
  logic         any_seen;
  logic         ovf_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] opp(input logic [1:0] d);
    case (d)
      2'd0:    return 2'd1;  // LEFT  <-> RIGHT
      2'd1:    return 2'd0;
      2'd2:    return 2'd3;  // UP    <-> DOWN
      default: return 2'd2;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_dir = 2'd1;
    m_any = 1'b0;
    m_ovf = 1'b0;
    for (int b = 0; b < 4; b++) begin
      pipe[b] = '0; hist[b] = '0; hist_n[b] = 0; stable[b] = 1'b0; rise1[b] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [1:0] cand, last;
    logic       valid, legal, pop, s;
    valid = rise1[0] | rise1[1] | rise1[2] | rise1[3];
    cand  = rise1[0] ? 2'd2 : rise1[1] ? 2'd0 : rise1[2] ? 2'd3 : 2'd1;
    m_any = valid;
    m_ovf = 1'b0;
    if (restart) begin
      exp_q.delete();
      m_dir = 2'd1;
    end else begin
      last  = (exp_q.size() > 0) ? exp_q[$] : m_dir;
      legal = valid && cand != last && cand != opp(last);
      pop   = tick && exp_q.size() > 0;
      if (pop) m_dir = exp_q.pop_front();
      if (legal) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(cand);
        else m_ovf = 1'b1;
      end
    end
    // A level change is accepted once D consecutive synced samples disagree
    // with the current debounced level.
    for (int b = 0; b < 4; b++) begin
      s = pipe[b][1];
      pipe[b] = {pipe[b][0], raw[b]};
      hist[b] = {hist[b][D-2:0], s};
      if (hist_n[b] < D) hist_n[b]++;
      rise1[b] = 1'b0;
      if (hist_n[b] == D && hist[b] == (stable[b] ? {D{1'b0}} : {D{1'b1}})) begin
        stable[b] = ~stable[b];
        rise1[b]  = stable[b];
      end
    end
  endtask

  task automatic compare_all();
    check("dir", dir_o, m_dir);
    check("count", q_count_o, 32'(exp_q.size()));
    check("any_press", any_press_o, m_any);
    check("overflow", overflow_o, m_ovf);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    compare_all();
    any_seen = any_seen | any_press_o;
    ovf_seen = ovf_seen | overflow_o;
  endtask

  task automatic run(input int n);
    repeat (n) do_cycle();
  endtask

  task automatic press(input logic [3:0] mask);
    raw = mask; run(8);
    raw = '0;   run(8);
  endtask

  task automatic tick_once();
    tick = 1'b1; do_cycle(); tick = 1'b0; run(1);
  endtask

  task automatic restart_once();
    restart = 1'b1; do_cycle(); restart = 1'b0; run(1);
  endtask

  logic [1:0] seq[4];

  initial begin
    rst = 1'b1; raw = '0; tick = 1'b0; restart = 1'b0;
    any_seen = 1'b0; ovf_seen = 1'b0;
    model_reset();
    #3;
    check("reset_dir", dir_o, 2'd1);
    check("reset_count", q_count_o, 0);
    compare_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. basic path and press latency
    any_seen = 1'b0;
    raw = 4'b0001; run(6);
    check("t1_count_early", q_count_o, 0);
    run(1);
    check("t1_count", q_count_o, 1);
    check("t1_any", any_press_o, 1);
    run(3); raw = '0; run(8);
    tick_once();
    check("t1_dir_up", dir_o, 2'd2);
    check("t1_count_empty", q_count_o, 0);

    // 2. bounce rejection
    any_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      raw[0] = ~raw[0]; run(2);
    end
    raw = '0; run(8);
    check("t2_no_press", any_seen, 0);
    check("t2_count", q_count_o, 0);

    // 3. reversal and repeat filtering
    restart_once();
    any_seen = 1'b0;
    press(4'b0010);
    check("t3_rev_any", any_seen, 1);
    check("t3_rev_count", q_count_o, 0);
    press(4'b0001); press(4'b0100); press(4'b0001);
    check("t3_filter_count", q_count_o, 1);
    tick_once();
    check("t3_dir", dir_o, 2'd2);

    // 4. overflow and drain order
    restart_once();
    press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
    check("t4_full", q_count_o, 4);
    ovf_seen = 1'b0;
    press(4'b0001);
    check("t4_ovf_seen", ovf_seen, 1);
    check("t4_full_after", q_count_o, 4);
    seq[0] = 2'd2; seq[1] = 2'd0; seq[2] = 2'd3; seq[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick_once();
      check("t4_drain_dir", dir_o, seq[i]);
    end
    check("t4_drained", q_count_o, 0);

    // 5a. simultaneous U and R
    restart_once();
    press(4'b1001);
    check("t5_simul_count", q_count_o, 1);
    tick_once();
    check("t5_simul_dir", dir_o, 2'd2);

    // 5b. full queue, press coinciding with tick
    restart_once();
    press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
    ovf_seen = 1'b0;
    raw = 4'b0001; run(6);
    tick = 1'b1; do_cycle(); tick = 1'b0;
    check("t5_full_tick_count", q_count_o, 4);
    run(1); raw = '0; run(8);
    check("t5_no_ovf", ovf_seen, 0);
    check("t5_dir", dir_o, 2'd2);
    repeat (4) tick_once();

    // 6a. restart beats a same-cycle tick
    restart_once();
    press(4'b0001); press(4'b0010); press(4'b0100);
    check("t6_three", q_count_o, 3);
    restart = 1'b1; tick = 1'b1; do_cycle(); restart = 1'b0; tick = 1'b0;
    check("t6_restart_count", q_count_o, 0);
    check("t6_restart_dir", dir_o, 2'd1);

    // 6b. asynchronous reset in the middle of a debounce
    press(4'b0001);
    raw = 4'b0001; run(3);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("t6_async_count", q_count_o, 0);
    check("t6_async_dir", dir_o, 2'd1);
    compare_all();
    @(posedge clk); #1;
    rst = 1'b0;
    run(6);
    check("t6_fresh_early", q_count_o, 0);
    run(1);
    check("t6_fresh", q_count_o, 1);
    raw = '0; run(8);

    // randomized phase, every cycle checked against the model
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 2) == 0) raw = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 7)) begin
        tick    = ($urandom_range(0, 3) == 0);
        restart = ($urandom_range(0, 59) == 0);
        do_cycle();
      end
      tick = 1'b0; restart = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dir_input_ctrl.md
Name: dir_input_ctrl

Overview:
- Producer side of the player-direction interface for the snake game.
- Conditions the four raw push-buttons: 2-FF synchronise, debounce, rising-edge detect.
- Filters each press against illegal moves (reversal, repeat) and buffers accepted turns in a small FIFO.
- The game engine consumes one turn per game step via tick_i. The block also provides a debounced any-press pulse that the game-over state uses to restart.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clocks needed to accept a level change (10 ms at 100 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- QUEUE_DEPTH, 4, number of buffered turns (power of two, minimum 2).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous reset, active-high
- btn_u  input  1  raw UP button, asynchronous
- btn_l  input  1  raw LEFT button, asynchronous
- btn_d  input  1  raw DOWN button, asynchronous
- btn_r  input  1  raw RIGHT button, asynchronous
- tick_i  input  1  one-clk strobe, one per game step; pops one turn
- restart_i  input  1  one-clk strobe; clears the queue and restores the default direction
- dir_o  output  2  current direction: 0=LEFT, 1=RIGHT, 2=UP, 3=DOWN
- q_count_o  output  $clog2(QUEUE_DEPTH)+1  number of queued turns
- any_press_o  output  1  one-clk pulse on any debounced rising edge
- overflow_o  output  1  one-clk pulse when an otherwise legal press is dropped because the queue is full

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: dir_o=1 (RIGHT), q_count_o=0, any_press_o=0, overflow_o=0. All sync flops, stable levels and debounce counters reset to 0.
- Synchroniser: each button passes through 2 flops before use.
- Debounce, per button:
  - Counter clears whenever the synced level equals the stable level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level toggles and the counter clears.
- Edge detect: a press is a 0->1 transition of the stable level, lasting one clk.
- Latency: press asserted at the synchroniser input to press pulse is 2 + DEBOUNCE_CYCLES clks. The queue push is registered one clk later.
- any_press_o: OR of the four press pulses, registered. It fires even when the press is rejected.
- Same-cycle presses: priority U > L > D > R. Only the winner is evaluated; the others are discarded silently.
- Reference direction "last":
  - the FIFO tail entry if q_count>0, else dir_o;
  - always sampled before any same-cycle pop.
- Acceptance rule:
  - Reject if cand == last.
  - Reject if cand == last ^ 2'b01 (the opposite direction).
  - Otherwise push.
  - Rejected presses change no state.
- Full queue:
  - A legal press with q_count==QUEUE_DEPTH and no same-cycle tick is dropped, and overflow_o pulses.
  - If tick_i is in the same cycle, the push is accepted and the count is unchanged.
- Pop: on tick_i with q_count>0, the head is popped and dir_o takes the head value at that clk edge (visible the next cycle). With an empty queue, tick_i has no effect.
- Push and pop in the same cycle: both occur; count is unchanged.
- restart_i: synchronous and highest priority. It empties the FIFO (pointers to 0) and sets dir_o=1. A tick or press in the same cycle is ignored; no overflow pulse. Debounce state is not cleared.
- Reset mid-debounce or mid-queue: all state returns to reset values immediately, regardless of clk.
- Pointers wrap modulo QUEUE_DEPTH; the count saturates by construction (never >DEPTH, never <0).

Decomposition:
- Shared package snake_pkg holds:
  - DIR_LEFT=2'd0, DIR_RIGHT=2'd1, DIR_UP=2'd2, DIR_DOWN=2'd3;
  - the dir_t 2-bit typedef;
  - an opposite() function (dir ^ 1).
- The top-level game and the snake engine share this package.
- Sub-module btn_debounce (synchroniser + debounce counter + edge pulse, parameterised by DEBOUNCE_CYCLES/CNT_W), instantiated 4x. The FIFO stays inline.

Test Plan (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=4):
1. Basic path: rst pulse -> dir_o=1, q_count_o=0. Hold btn_u for 10 clks -> any_press_o pulses once and q_count_o=1, 7 clks after the rising edge. Then tick_i -> dir_o=2 and q_count_o=0 the next cycle.
2. Bounce rejection: btn_u toggled every 2 clks for 20 clks, then held low -> no press, any_press_o stays 0, q_count_o=0.
3. Reversal and repeat filtering: with dir_o=1, press L -> rejected, q_count_o=0, any_press_o=1. Then press U, then D -> U queued, D rejected (opposite of tail); press U again -> rejected (repeat).
4. Overflow: press U, L, D, R, U in turn -> first four queued (q_count_o=4); the fifth U gives an overflow_o pulse. Four ticks -> dir_o sequence 2, 0, 3, 1, q_count_o=0.
5. Simultaneous events:
   - btn_u and btn_r reach their rising edge in the same cycle -> only 2 is pushed.
   - A press with the queue full coinciding with tick_i -> accepted, q_count_o stays 4, no overflow.
6. Restart and async reset:
   - restart_i with q_count_o=3 and tick_i in the same cycle -> q_count_o=0, dir_o=1.
   - Assert rst between clk edges during a debounce -> outputs reset immediately; no press after release until a fresh 4-clk stable level.
